// File: rtl/intersection_traffic_model.sv
// Vehicle-queue model for a two-road intersection: per-road saturating car queues that drain one
// car per PASS_CYCLES green cycles. Optional light-conflict monitor: INTERSECTION_CONFLICT_CHECK_EN.

// One road: queue counter, pass timer and EMPTY/WAIT/CROSS state.
// State encoding (visible on o_state): 0 EMPTY, 1 WAIT, 2 CROSS.
module intersection_road_queue #(
  parameter int QW          = 4,
  parameter int PASS_CYCLES = 2,
  parameter int TW          = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_arrive,
  input  logic [1:0]    i_light,
  output logic [QW-1:0] o_q,
  output logic          o_sense,
  output logic          o_depart,
  output logic          o_ovf,
  output logic [1:0]    o_state
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_WAIT  = 2'd1,
    S_CROSS = 2'd2
  } road_state_e;

  localparam logic [QW-1:0] QMAX   = '1;
  localparam logic [TW-1:0] T_LAST = TW'(PASS_CYCLES - 1);

  road_state_e   state_q, state_d;
  logic [QW-1:0] q_q, q_d;
  logic [TW-1:0] t_q, t_d;
  logic          dep_q, dep_d;
  logic          ovf_q, ovf_d;
  logic          green, red, dep_now, arr_ok;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_EMPTY;
      q_q     <= '0;
      t_q     <= '0;
      dep_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      t_q     <= t_d;
      dep_q   <= dep_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    t_d     = t_q;
    dep_d   = 1'b0;
    ovf_d   = ovf_q;
    dep_now = 1'b0;
    arr_ok  = 1'b0;
    green   = (i_light == 2'b00);
    red     = (i_light == 2'b01);

    // Timer accrues on green whether the road was waiting or already crossing;
    // yellow freezes partial progress, red throws it away.
    case (state_q)
      S_WAIT, S_CROSS: begin
        if (green) begin
          if (t_q == T_LAST) begin
            dep_now = 1'b1;
            t_d     = '0;
          end else begin
            t_d = t_q + TW'(1);
          end
        end else if (red) begin
          t_d = '0;
        end
      end
      default: t_d = '0;
    endcase

    // A departure frees a slot in the same cycle, so a full queue can still accept.
    arr_ok  = i_arrive & ((q_q != QMAX) | dep_now);
    ovf_d   = ovf_q | (i_arrive & ~arr_ok);
    q_d     = q_q + QW'(arr_ok) - QW'(dep_now);
    dep_d   = dep_now;

    if (q_d == '0)  state_d = S_EMPTY;
    else if (green) state_d = S_CROSS;
    else            state_d = S_WAIT;
  end

  assign o_q      = q_q;
  assign o_sense  = (q_q != '0);
  assign o_depart = dep_q;
  assign o_ovf    = ovf_q;
  assign o_state  = state_q;

endmodule

module intersection_traffic_model #(
  parameter int QW          = 4,
  parameter int PASS_CYCLES = 2,
  parameter int TW          = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_arrive_a,
  input  logic          i_arrive_b,
  input  logic [1:0]    i_LA,
  input  logic [1:0]    i_LB,
  output logic          o_TA,
  output logic          o_TB,
  output logic [QW-1:0] o_qa,
  output logic [QW-1:0] o_qb,
  output logic          o_depart_a,
  output logic          o_depart_b,
  output logic          o_ovf_a,
  output logic          o_ovf_b,
  output logic          o_conflict,
  output logic [1:0]    o_state_a,
  output logic [1:0]    o_state_b
);

  intersection_road_queue #(.QW(QW), .PASS_CYCLES(PASS_CYCLES), .TW(TW)) u_road_a (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_arrive (i_arrive_a),
    .i_light  (i_LA),
    .o_q      (o_qa),
    .o_sense  (o_TA),
    .o_depart (o_depart_a),
    .o_ovf    (o_ovf_a),
    .o_state  (o_state_a)
  );

  intersection_road_queue #(.QW(QW), .PASS_CYCLES(PASS_CYCLES), .TW(TW)) u_road_b (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_arrive (i_arrive_b),
    .i_light  (i_LB),
    .o_q      (o_qb),
    .o_sense  (o_TB),
    .o_depart (o_depart_b),
    .o_ovf    (o_ovf_b),
    .o_state  (o_state_b)
  );

`ifdef INTERSECTION_CONFLICT_CHECK_EN
  // Any cycle where neither road shows RED is an unsafe light combination.
  logic conflict_q, conflict_d;

  always_comb begin
    conflict_d = conflict_q | ((i_LA != 2'b01) && (i_LB != 2'b01));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) conflict_q <= 1'b0;
    else       conflict_q <= conflict_d;
  end

  assign o_conflict = conflict_q;
`else
  assign o_conflict = 1'b0;
`endif

endmodule
